// File: rtl/dbus_ram_responder.sv
// dbus_ram_responder: single-outstanding data-bus slave backed by a 64-bit wide RAM.
//
// A request is accepted in IDLE, waits LATENCY cycles, performs one read or
// byte-strobed write against the RAM, and returns a one-cycle addr_ok/data_ok
// pulse. The responder then waits for valid to drop before it can accept again.
//
// Parameters:
//   DEPTH   - number of 64-bit words (power of two, 2..65536)
//   LATENCY - wait cycles between acceptance and the access (0..255)
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset (RAM contents are not reset)
//   dreq  - request: valid, addr, size (ignored), strobe, data
//   dresp - registered response: addr_ok, data_ok, data

package dbus_ram_responder_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

module dbus_ram_responder
  import dbus_ram_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp, StDrain} state_e;

  state_e      r_state;
  logic [7:0]  r_cnt;
  logic [63:0] r_addr;
  logic [7:0]  r_strobe;
  logic [63:0] r_data;
  dbus_resp_t  r_resp;

  logic [63:0] r_mem [DEPTH];

  logic [AW-1:0] w_idx;
  logic          w_in_range;
  logic          w_access;
  logic          w_write;
  logic          w_unused;

  assign w_idx      = r_addr[3 +: AW];
  // Any set bit above the index field means addr[63:3] >= DEPTH.
  assign w_in_range = (r_addr[63:3+AW] == '0);
  assign w_access   = (r_state == StWait) && (r_cnt == 8'd0);
  assign w_write    = |r_strobe;

  // size and the byte offset never influence indexing or masking.
  assign w_unused = ^{dreq.size, r_addr[2:0]};

  assign dresp = r_resp;

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_cnt    <= 8'd0;
      r_addr   <= 64'd0;
      r_strobe <= 8'd0;
      r_data   <= 64'd0;
      r_resp   <= '0;
    end else begin
      r_resp.addr_ok <= 1'b0;
      r_resp.data_ok <= 1'b0;
      case (r_state)
        StIdle: begin
          if (dreq.valid) begin
            r_addr   <= dreq.addr;
            r_strobe <= dreq.strobe;
            r_data   <= dreq.data;
            r_cnt    <= 8'(LATENCY);
            r_state  <= StWait;
          end
        end
        StWait: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            r_state        <= StResp;
            r_resp.addr_ok <= 1'b1;
            r_resp.data_ok <= 1'b1;
            // Writes and out-of-range reads return zero.
            r_resp.data    <= (!w_write && w_in_range) ? r_mem[w_idx] : 64'd0;
          end
        end
        StResp: begin
          r_state <= StDrain;
        end
        StDrain: begin
          // A valid still held from the finished request must not be re-accepted.
          if (!dreq.valid) begin
            r_state <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // RAM write port; contents survive reset. Reset forces StIdle, so no write
  // can fire while rst is low.
  always_ff @(posedge clk) begin
    if (w_access && w_write && w_in_range) begin
      for (int i = 0; i < 8; i++) begin
        if (r_strobe[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dbus_ram_responder.sv
// Testbench for dbus_ram_responder: two instances (LATENCY=2/DEPTH=256 and
// LATENCY=0/DEPTH=16). Stimulus pushes expected responses into per-instance
// queues; monitors pop and compare on every data_ok, including response timing.

module tb_dbus_ram_responder;
  import dbus_ram_responder_pkg::*;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  dbus_req_t  req0, req1;
  dbus_resp_t resp0, resp1;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc;
  int   total;
  int   bad;
  int   nresp0;
  int   nresp1;

  dbus_ram_responder #(.DEPTH(256), .LATENCY(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .dreq  (req0),
    .dresp (resp0)
  );

  dbus_ram_responder #(.DEPTH(16), .LATENCY(0)) dut_l0 (
    .clk   (clk),
    .rst   (rst),
    .dreq  (req1),
    .dresp (resp1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Monitors: every data_ok must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && resp0.data_ok) begin
      nresp0 = nresp0 + 1;
      total  = total + 1;
      if (q0.size() == 0) begin
        bad = bad + 1;
        $display("FAIL resp0_unexpected: got data_ok data=%h at cyc %0d, required no response",
                 resp0.data, cyc);
      end else begin
        e = q0.pop_front();
        if (resp0.data !== e.data || resp0.addr_ok !== 1'b1 || cyc != e.cyc) begin
          bad = bad + 1;
          $display("FAIL resp0: got data=%h addr_ok=%b cyc=%0d, required data=%h addr_ok=1 cyc=%0d",
                   resp0.data, resp0.addr_ok, cyc, e.data, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && resp1.data_ok) begin
      nresp1 = nresp1 + 1;
      total  = total + 1;
      if (q1.size() == 0) begin
        bad = bad + 1;
        $display("FAIL resp1_unexpected: got data_ok data=%h at cyc %0d, required no response",
                 resp1.data, cyc);
      end else begin
        e = q1.pop_front();
        if (resp1.data !== e.data || resp1.addr_ok !== 1'b1 || cyc != e.cyc) begin
          bad = bad + 1;
          $display("FAIL resp1: got data=%h addr_ok=%b cyc=%0d, required data=%h addr_ok=1 cyc=%0d",
                   resp1.data, resp1.addr_ok, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic drive(input int which, input logic v, input logic [63:0] addr,
                       input logic [7:0] strb, input logic [63:0] wdata);
    if (which == 0) begin
      req0.valid  = v;
      req0.addr   = addr;
      req0.size   = 3'($urandom_range(0, 7));
      req0.strobe = strb;
      req0.data   = wdata;
    end else begin
      req1.valid  = v;
      req1.addr   = addr;
      req1.size   = 3'($urandom_range(0, 7));
      req1.strobe = strb;
      req1.data   = wdata;
    end
  endtask

  function automatic int qsize(input int which);
    return (which == 0) ? q0.size() : q1.size();
  endfunction

  // Bounded wait for all expected responses of one instance.
  task automatic wait_empty(input int which);
    int n;
    n = 0;
    while (qsize(which) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (qsize(which) != 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL resp%0d_timeout: got no data_ok within 50 cycles, required a response", which);
      if (which == 0) q0.delete();
      else q1.delete();
    end
  endtask

  // One request with valid for a single accepting edge; fields are scrambled
  // afterwards so a DUT using live values would misbehave.
  task automatic issue(input int which, input logic [63:0] addr, input logic [7:0] strb,
                       input logic [63:0] wdata, input logic [63:0] exp_data);
    exp_t e;
    int   lat;
    @(negedge clk);
    lat      = (which == 0) ? 2 : 0;
    e.data   = exp_data;
    e.cyc    = cyc + lat + 2;
    drive(which, 1'b1, addr, strb, wdata);
    if (which == 0) q0.push_back(e);
    else q1.push_back(e);
    @(negedge clk);
    drive(which, 1'b0, ~addr, ~strb, ~wdata);
    wait_empty(which);
    @(negedge clk);
    @(negedge clk);
    if (which == 0) check64("resp0_data_hold", resp0.data, exp_data);
    else check64("resp1_data_hold", resp1.data, exp_data);
  endtask

  initial begin
    int   n0;
    exp_t e;
    total  = 0;
    bad    = 0;
    nresp0 = 0;
    nresp1 = 0;
    rst    = 1'b0;
    drive(0, 1'b0, 64'd0, 8'd0, 64'd0);
    drive(1, 1'b0, 64'd0, 8'd0, 64'd0);
    repeat (3) @(negedge clk);
    check64("reset_addr_ok0", {63'd0, resp0.addr_ok}, 64'd0);
    check64("reset_data_ok0", {63'd0, resp0.data_ok}, 64'd0);
    check64("reset_data0", resp0.data, 64'd0);
    check64("reset_addr_ok1", {63'd0, resp1.addr_ok}, 64'd0);
    check64("reset_data_ok1", {63'd0, resp1.data_ok}, 64'd0);
    check64("reset_data1", resp1.data, 64'd0);
    rst = 1'b1;

    // Full write, read-back, partial merge.
    issue(0, 64'h10, 8'hFF, 64'h1122334455667788, 64'd0);
    issue(0, 64'h10, 8'h00, 64'd0, 64'h1122334455667788);
    issue(0, 64'h10, 8'h0F, 64'hAAAAAAAABBBBBBBB, 64'd0);
    issue(0, 64'h10, 8'h00, 64'd0, 64'h11223344BBBBBBBB);
    issue(0, 64'h0, 8'hFF, 64'h0123456789ABCDEF, 64'd0);
    issue(0, 64'h0, 8'h00, 64'd0, 64'h0123456789ABCDEF);

    // Out of range: 0x800 aliases index 0 if the range check were missing.
    issue(0, 64'h800, 8'h00, 64'd0, 64'd0);
    issue(0, 64'h800, 8'hFF, 64'hDEADBEEFDEADBEEF, 64'd0);
    issue(0, 64'h0, 8'h00, 64'd0, 64'h0123456789ABCDEF);

    // addr[2:0] ignored; upper-half and sparse strobes on index 2.
    issue(0, 64'h17, 8'hF0, 64'h5555666677778888, 64'd0);
    issue(0, 64'h10, 8'h00, 64'd0, 64'h55556666BBBBBBBB);
    issue(0, 64'h12, 8'h81, 64'h99000000000000AA, 64'd0);
    issue(0, 64'h10, 8'h00, 64'd0, 64'h99556666BBBBBBAA);
    issue(0, 64'h8000000000000010, 8'h00, 64'd0, 64'd0);

    // Valid held through and 3 cycles past data_ok: exactly one response.
    issue(0, 64'h0, 8'h00, 64'd0, 64'h0123456789ABCDEF);
    @(negedge clk);
    n0     = nresp0;
    e.data = 64'h99556666BBBBBBAA;
    e.cyc  = cyc + 4;
    drive(0, 1'b1, 64'h10, 8'h00, 64'd0);
    q0.push_back(e);
    wait_empty(0);
    repeat (3) @(negedge clk);
    drive(0, 1'b0, 64'h10, 8'h00, 64'd0);
    repeat (6) @(negedge clk);
    check64("held_valid_resp_count", 64'(nresp0 - n0), 64'd1);
    issue(0, 64'h0, 8'h00, 64'd0, 64'h0123456789ABCDEF);

    // Reset during WAIT of a write: abandoned, memory unchanged.
    @(negedge clk);
    drive(0, 1'b1, 64'h0, 8'hFF, 64'hFFFFFFFFFFFFFFFF);
    @(negedge clk);
    drive(0, 1'b0, 64'h0, 8'h00, 64'd0);
    #2 rst = 1'b0;
    #1;
    check64("async_reset_data", resp0.data, 64'd0);
    check64("async_reset_data_ok", {63'd0, resp0.data_ok}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    issue(0, 64'h0, 8'h00, 64'd0, 64'h0123456789ABCDEF);

    // LATENCY=0 instance.
    issue(1, 64'h8, 8'hFF, 64'hA5A5A5A5A5A5A5A5, 64'd0);
    issue(1, 64'h8, 8'h00, 64'd0, 64'hA5A5A5A5A5A5A5A5);
    issue(1, 64'h80, 8'h00, 64'd0, 64'd0);
    issue(1, 64'h9, 8'h3C, 64'h0011223344556677, 64'd0);
    issue(1, 64'h8, 8'h00, 64'd0, 64'hA5A522334455A5A5);

    repeat (5) @(negedge clk);
    check64("q0_drained", 64'(q0.size()), 64'd0);
    check64("q1_drained", 64'(q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbus_ram_responder.md
DBUS_RAM_RESPONDER -- requirements
Module: dbus_ram_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 64-bit words (power of two, 2..65536).
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles before response (0..255).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port dreq  input  dbus_req_t  request from initiator (valid, addr[63:0], size[2:0], strobe[7:0], data[63:0]).
REQ-006 SHALL have port dresp  output  dbus_resp_t  response to initiator (addr_ok, data_ok, data[63:0]); all fields registered.

Function
REQ-007 SHALL implement states IDLE, WAIT, RESP, DRAIN, encoded in one state register.
REQ-008 SHALL, in IDLE with dreq.valid=1 at a rising edge, capture addr, strobe, data into holding registers, load an 8-bit counter with LATENCY, and enter WAIT.
REQ-009 SHALL, in WAIT, decrement the counter each edge while it is nonzero; when it is zero, perform the access and enter RESP.
REQ-010 SHALL assert dresp.addr_ok=1 and dresp.data_ok=1 for exactly one cycle in RESP; first visible LATENCY+1 cycles after the accepting edge (LATENCY=2: accept at edge E0, data_ok high from E3 to E4).
REQ-011 SHALL use word index = captured addr[3 +: log2(DEPTH)], and treat addr[63:3] >= DEPTH as out of range.
REQ-012 SHALL treat captured strobe=0 as a read: dresp.data = stored word at index; 0 if out of range.
REQ-013 SHALL treat captured strobe!=0 as a write: for each i with strobe[i]=1, update byte i (bits 8i+7:8i) with data byte i; other bytes unchanged; dresp.data=0.
REQ-014 SHALL ignore out-of-range writes, leaving memory unchanged, and SHALL still respond normally.
REQ-015 SHALL ignore dreq.size and addr[2:0] for masking and indexing; byte selection is by strobe only.
REQ-016 SHALL ignore changes on dreq fields after acceptance; the access uses captured values only.
REQ-017 SHALL go from RESP to DRAIN unconditionally; in DRAIN, SHALL stay while dreq.valid=1 and return to IDLE on the first edge with dreq.valid=0, so a lingering valid is never accepted twice.
REQ-018 SHALL hold dresp.addr_ok=0, dresp.data_ok=0 in IDLE, WAIT, DRAIN; dresp.data SHALL hold its last value until the next RESP.
REQ-019 SHALL accept at most one outstanding request; requests in WAIT/RESP/DRAIN are not queued.
REQ-020 SHALL make a read issued after a completed write to the same index return the written bytes merged with the previous contents.

Reset
REQ-021 SHALL, while rst=0, force state=IDLE, counter=0, dresp.addr_ok=0, dresp.data_ok=0, dresp.data=0, and holding registers=0, independent of clk.
REQ-022 SHALL abandon any transaction in progress when rst falls mid-operation, with no memory update if the access had not yet occurred.
REQ-023 SHALL leave memory contents unaffected by rst.
REQ-024 SHALL resume operation on the first rising edge after rst returns to 1, starting in IDLE.

Verification
REQ-025 SHALL be covered by: full write addr=0x10, strobe=0xFF, data=0x1122334455667788; then read addr=0x10 -> data_ok one cycle, data=0x1122334455667788, 3 cycles after accept.
REQ-026 SHALL be covered by: partial write addr=0x10, strobe=0x0F, data=0xAAAAAAAABBBBBBBB over the prior value; read -> 0x11223344BBBBBBBB.
REQ-027 SHALL be covered by: read addr=DEPTH*8 (out of range) -> data=0; write there -> responds, and a read of index 0 is unchanged.
REQ-028 SHALL be covered by: valid held high 3 cycles after data_ok -> exactly one response; new request accepted only after valid drops then rises.
REQ-029 SHALL be covered by: rst pulsed low during WAIT of a write -> no data_ok, target word unchanged, next request serviced normally.
REQ-030 SHALL be covered by: LATENCY=0 build, read -> data_ok visible 1 cycle after the accepting edge.
